// File: rtl/enums_pkg.sv
// Shared opcode, flag layout and op-class helpers for the pipelined ALU.
package enums_pkg;

  typedef enum logic [3:0] {
    NOP    = 4'd0,
    OR     = 4'd1,
    NOR    = 4'd2,
    AND    = 4'd3,
    NAND   = 4'd4,
    XOR    = 4'd5,
    ADD    = 4'd6,
    SUB    = 4'd7,
    SHIFTL = 4'd8,
    SHIFTR = 4'd9
  } OP_CODE;

  typedef struct packed {
    logic c;
    logic v;
    logic n;
    logic z;
  } alu_flags_t;

  localparam int FLAG_W = 4;

  // Encodings above SHIFTR are undefined and must report all-zero flags.
  function automatic logic op_defined(input OP_CODE op);
    return (4'(op) <= 4'(SHIFTR));
  endfunction

  function automatic logic op_is_arith(input OP_CODE op);
    return (op == ADD) || (op == SUB);
  endfunction

endpackage

// File: rtl/alu_pipe_core.sv
// Combinational ALU datapath: (op, a, b, cin) -> result with carry/borrow and signed overflow.
module alu_pipe_core
  import enums_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  OP_CODE           op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] res,
  output logic             c,
  output logic             v
);

  logic [WIDTH:0] raw;
  logic [WIDTH:0] shr;
  logic [WIDTH:0] cin_ext;

  assign cin_ext = {{WIDTH{1'b0}}, cin};

  always_comb begin
    raw = '0;
    shr = '0;
    c   = 1'b0;
    v   = 1'b0;
    case (op)
      OR:   raw = {1'b0, a | b};
      NOR:  raw = {1'b0, ~(a | b)};
      AND:  raw = {1'b0, a & b};
      NAND: raw = {1'b0, ~(a & b)};
      XOR:  raw = {1'b0, a ^ b};
      ADD: begin
        raw = {1'b0, a} + {1'b0, b} + cin_ext;
        c   = raw[WIDTH];
        v   = (a[WIDTH-1] == b[WIDTH-1]) && (raw[WIDTH-1] != a[WIDTH-1]);
      end
      SUB: begin
        // Bit WIDTH of the extended difference is set exactly when a < b+cin.
        raw = {1'b0, a} - {1'b0, b} - cin_ext;
        c   = raw[WIDTH];
        v   = (a[WIDTH-1] != b[WIDTH-1]) && (raw[WIDTH-1] != a[WIDTH-1]);
      end
      SHIFTL: begin
        // The guard bit above a catches the last bit shifted out.
        raw = {1'b0, a} << b;
        c   = raw[WIDTH];
      end
      SHIFTR: begin
        shr = {a, 1'b0} >> b;
        raw = {1'b0, shr[WIDTH:1]};
        c   = shr[0];
      end
      default: raw = '0;
    endcase
  end

  assign res = raw[WIDTH-1:0];

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready on both sides, tag pass-through and stored carry.
module alu_pipe
  import enums_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  OP_CODE           in_op,
  input  logic             in_chain,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output alu_flags_t       out_flags,
  output logic [TAG_W-1:0] out_tag
);

  // Handshake: a beat transfers on any rising edge where valid && ready.
  // A producer holds valid and payload until that edge; ready may depend on
  // the consumer's state but valid never depends on ready.

  logic             s1_v;
  OP_CODE           s1_op;
  logic [WIDTH-1:0] s1_res;
  logic             s1_c;
  logic             s1_vf;
  logic [TAG_W-1:0] s1_tag;
  logic             carry_q;

  logic             adv1;
  logic             adv2;
  logic             accept;
  logic             cin;
  logic [WIDTH-1:0] core_res;
  logic             core_c;
  logic             core_v;
  alu_flags_t       s2_flags;

  assign adv2     = !out_valid || out_ready;
  assign adv1     = !s1_v || adv2;
  assign in_ready = adv1;
  assign accept   = in_valid && in_ready;
  assign cin      = in_chain && op_is_arith(in_op) && carry_q;

  alu_pipe_core #(.WIDTH(WIDTH)) u_core (
    .op  (in_op),
    .a   (in_a),
    .b   (in_b),
    .cin (cin),
    .res (core_res),
    .c   (core_c),
    .v   (core_v)
  );

  always_comb begin
    s2_flags   = '0;
    s2_flags.c = s1_c;
    s2_flags.v = s1_vf;
    s2_flags.n = s1_res[WIDTH-1];
    s2_flags.z = op_defined(s1_op) && (s1_res == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v      <= 1'b0;
      s1_op     <= NOP;
      s1_res    <= '0;
      s1_c      <= 1'b0;
      s1_vf     <= 1'b0;
      s1_tag    <= '0;
      carry_q   <= 1'b0;
      out_valid <= 1'b0;
      out_res   <= '0;
      out_flags <= '0;
      out_tag   <= '0;
    end else begin
      if (adv1) begin
        s1_v <= in_valid;
        if (in_valid) begin
          s1_op  <= in_op;
          s1_res <= core_res;
          s1_c   <= core_c;
          s1_vf  <= core_v;
          s1_tag <= in_tag;
        end
      end
      if (adv2) begin
        out_valid <= s1_v;
        if (s1_v) begin
          out_res   <= s1_res;
          out_flags <= s2_flags;
          out_tag   <= s1_tag;
        end
      end
      if (accept && op_is_arith(in_op)) begin
        carry_q <= core_c;
      end
    end
  end

endmodule
